// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, status and memory-side signals for dmem_arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 8
);
    logic                  req0, req1;
    logic                  wen0, wen1;
    logic [ADDR_BITS-1:0]  addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  busy;
    logic [7:0]            contention_cnt;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req0, req1, wen0, wen1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy, contention_cnt,
               mem_addr, mem_wdata, mem_wen
    );

    modport master (
        output req0, req1, wen0, wen1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy, contention_cnt,
               mem_addr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port, registered-output data memory
// between two requesters; one transaction in flight, all outputs registered.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 8
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, READ} state_t;

    state_t state;
    logic   last_grant;   // port granted most recently; the other wins a tie
    logic   sel;          // port owning the transaction in flight
    logic   pick1;
    logic   both_req;

    // NOTE: combinational block assigns every output unconditionally, so no latch can form.
    always_comb begin
        both_req = bus.req0 && bus.req1;
        pick1    = bus.req1 && (!bus.req0 || !last_grant);
    end

    // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            last_grant         <= 1'b1;
            sel                <= 1'b0;
            bus.gnt0           <= 1'b0;
            bus.gnt1           <= 1'b0;
            bus.rvalid0        <= 1'b0;
            bus.rvalid1        <= 1'b0;
            bus.rdata0         <= '0;
            bus.rdata1         <= '0;
            bus.busy           <= 1'b0;
            bus.contention_cnt <= '0;
            bus.mem_addr       <= '0;
            bus.mem_wdata      <= '0;
            bus.mem_wen        <= 1'b0;
        end else begin
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        if (both_req && bus.contention_cnt != 8'hFF)
                            bus.contention_cnt <= bus.contention_cnt + 8'd1;
                        sel           <= pick1;
                        last_grant    <= pick1;
                        bus.mem_addr  <= pick1 ? bus.addr1  : bus.addr0;
                        bus.mem_wdata <= pick1 ? bus.wdata1 : bus.wdata0;
                        bus.mem_wen   <= pick1 ? bus.wen1   : bus.wen0;
                        bus.gnt0      <= !pick1;
                        bus.gnt1      <= pick1;
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_wen <= 1'b0;
                    if (bus.mem_wen) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (sel) begin
                        bus.rdata1  <= bus.mem_rdata;
                        bus.rvalid1 <= 1'b1;
                    end else begin
                        bus.rdata0  <= bus.mem_rdata;
                        bus.rvalid0 <= 1'b1;
                    end
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// single-port memory (registered read output) attached to the memory side.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wen_cycles = 0;
    logic [7:0] mem [256];

    dmem_arbiter_if #(.DATA_WIDTH(8), .ADDR_BITS(8)) bus ();

    dmem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(negedge clk) if (bus.mem_wen) wen_cycles++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit p, input bit req, input bit wen,
                         input logic [7:0] a, input logic [7:0] d);
        if (p) begin
            bus.req1 = req; bus.wen1 = wen; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = req; bus.wen0 = wen; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    // Entered and left at a falling edge with the arbiter in IDLE.
    task automatic do_write(input bit p, input logic [7:0] a, input logic [7:0] d);
        drive(p, 1'b1, 1'b1, a, d);
        @(negedge clk);
        check("wr_gnt",       p ? bus.gnt1 : bus.gnt0, 1);
        check("wr_gnt_other", p ? bus.gnt0 : bus.gnt1, 0);
        check("wr_mem_wen",   bus.mem_wen, 1);
        check("wr_mem_addr",  bus.mem_addr, a);
        check("wr_mem_wdata", bus.mem_wdata, d);
        check("wr_busy",      bus.busy, 1);
        drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("wr_idle_busy", bus.busy, 0);
        check("wr_idle_wen",  bus.mem_wen, 0);
        check("wr_idle_gnt",  p ? bus.gnt1 : bus.gnt0, 0);
    endtask

    task automatic do_read(input bit p, input logic [7:0] a, input logic [7:0] exp);
        drive(p, 1'b1, 1'b0, a, 8'h00);
        @(negedge clk);
        check("rd_gnt",      p ? bus.gnt1 : bus.gnt0, 1);
        check("rd_mem_wen",  bus.mem_wen, 0);
        check("rd_mem_addr", bus.mem_addr, a);
        drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("rd_wait_busy",   bus.busy, 1);
        check("rd_wait_rvalid", p ? bus.rvalid1 : bus.rvalid0, 0);
        check("rd_wait_gnt",    p ? bus.gnt1 : bus.gnt0, 0);
        @(negedge clk);
        check("rd_rvalid", p ? bus.rvalid1 : bus.rvalid0, 1);
        check("rd_rdata",  p ? bus.rdata1 : bus.rdata0, exp);
        check("rd_busy",   bus.busy, 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gnt"},    {bus.gnt1, bus.gnt0}, 0);
        check({tag, "_rvalid"}, {bus.rvalid1, bus.rvalid0}, 0);
        check({tag, "_busy"},   bus.busy, 0);
        check({tag, "_wen"},    bus.mem_wen, 0);
        check({tag, "_rdata0"}, bus.rdata0, 0);
        check({tag, "_rdata1"}, bus.rdata1, 0);
        check({tag, "_addr"},   bus.mem_addr, 0);
        check({tag, "_wdata"},  bus.mem_wdata, 0);
        check({tag, "_cnt"},    bus.contention_cnt, 0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_cleared("por");

        // Single write then read on port 0; mem_wen must pulse exactly once
        w0 = wen_cycles;
        do_write(1'b0, 8'h10, 8'hA5);
        do_read(1'b0, 8'h10, 8'hA5);
        check("wen_one_cycle", wen_cycles - w0, 1);

        // Preload for contention; all by port 0 so last_grant ends at 0
        do_write(1'b0, 8'h01, 8'h11);
        do_write(1'b0, 8'h02, 8'h22);

        // Reset in the READ cycle of a port-0 read aborts the completion
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("abort_gnt", bus.gnt0, 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("abort_in_read", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_rvalid", bus.rvalid0, 0);
        rst = 1'b0;
        @(negedge clk);
        check_cleared("abort");

        // Both ports reading and held: grants alternate 0,1,0,1 starting at port 0
        drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
        for (int k = 0; k < 4; k++) begin
            bit p;
            p = k[0];
            @(negedge clk);
            check("cont_gnt0", bus.gnt0, !p);
            check("cont_gnt1", bus.gnt1, p);
            check("cont_cnt",  bus.contention_cnt, k + 1);
            @(negedge clk);
            check("cont_busy", bus.busy, 1);
            @(negedge clk);
            check("cont_rvalid", p ? bus.rvalid1 : bus.rvalid0, 1);
            check("cont_rdata",  p ? bus.rdata1 : bus.rdata0, p ? 8'h22 : 8'h11);
            if (k == 3) begin
                drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
                drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end

        // Cross-port coherency
        do_write(1'b1, 8'hFF, 8'h3C);
        do_read(1'b0, 8'hFF, 8'h3C);
        check("xport_rdata1_held", bus.rdata1, 8'h22);

        // 300 contended read arbitrations saturate the counter
        drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
        repeat (900) @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("sat_drained", bus.busy, 0);
        check("sat_cnt", bus.contention_cnt, 8'hFF);

        // Back-to-back port-1 writes, one grant every two cycles, then readback
        for (int i = 0; i < 8; i++) do_write(1'b1, 8'(i), 8'(8'h50 + i));
        for (int i = 0; i < 8; i++) do_read(1'b1, 8'(i), 8'(8'h50 + i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
